// File: rtl/led_stat.sv
// led_stat: CPU activity statistics with a paged LED display.
//
// Four saturating counters (cycles, conditional branches, taken branches,
// jumps) run while the CPU is not halted. One source is selected onto the
// registered LED output; wide counters are shown one LED_W-bit page at a time.
// A freeze request captures the display and holds it while counting continues.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-low
//   halt     - CPU halted; counters hold
//   br_cond  - pulse per retired conditional branch
//   br_taken - qualifies br_cond; branch was taken
//   jmp      - pulse per retired unconditional jump
//   pc       - program counter (word address)
//   in_addr  - address switch value
//   sel      - display source select
//   page     - 0: counter low page, 1: counter high page (zero-extended)
//   clr      - synchronous clear of all counters
//   freeze   - hold the LED display
//   leds     - registered LED drive
module led_stat #(
    parameter int CNT_W  = 32,
    parameter int LED_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              br_cond,
    input  logic              br_taken,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [2:0]        sel,
    input  logic              page,
    input  logic              clr,
    input  logic              freeze,
    output logic [LED_W-1:0]  leds
);

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } disp_state_t;

    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_cond_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_jmp_cnt;
    logic [LED_W-1:0] r_leds;
    disp_state_t      r_state;

    logic [CNT_W-1:0] w_cnt;
    logic [LED_W-1:0] w_src;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != '1)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // Statistics counters: reset beats clr, clr beats halt and increments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cyc_cnt   <= '0;
            r_cond_cnt  <= '0;
            r_taken_cnt <= '0;
            r_jmp_cnt   <= '0;
        end else if (clr) begin
            r_cyc_cnt   <= '0;
            r_cond_cnt  <= '0;
            r_taken_cnt <= '0;
            r_jmp_cnt   <= '0;
        end else if (!halt) begin
            r_cyc_cnt   <= sat_inc(r_cyc_cnt, 1'b1);
            r_cond_cnt  <= sat_inc(r_cond_cnt, br_cond);
            r_taken_cnt <= sat_inc(r_taken_cnt, br_cond & br_taken);
            r_jmp_cnt   <= sat_inc(r_jmp_cnt, jmp);
        end
    end

    // Counter chosen for sel 010..101.
    always_comb begin
        w_cnt = '0;
        case (sel)
            3'b010:  w_cnt = r_cyc_cnt;
            3'b011:  w_cnt = r_cond_cnt;
            3'b100:  w_cnt = r_taken_cnt;
            3'b101:  w_cnt = r_jmp_cnt;
            default: w_cnt = '0;
        endcase
    end

    // Display source; page only slices counter sources.
    always_comb begin
        w_src = '0;
        case (sel)
            3'b000: begin
                // Reset indicator in the MSB, switch address just below it.
                w_src[LED_W-1]          = 1'b1;
                w_src[LED_W-2 -: ADDR_W] = in_addr;
            end
            3'b001:  w_src = LED_W'(pc);
            3'b010,
            3'b011,
            3'b100,
            3'b101:  w_src = page ? LED_W'(w_cnt >> LED_W) : w_cnt[LED_W-1:0];
            default: w_src = '0;
        endcase
    end

    // Display FSM. The edge that enters HELD captures the current source;
    // the edge that leaves HELD loads the source again, so the display is
    // live one cycle after freeze drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= LIVE;
            r_leds  <= '0;
        end else begin
            case (r_state)
                LIVE: begin
                    r_leds <= w_src;
                    if (freeze) begin
                        r_state <= HELD;
                    end
                end
                HELD: begin
                    if (!freeze) begin
                        r_state <= LIVE;
                        r_leds  <= w_src;
                    end
                end
                default: begin
                    r_state <= LIVE;
                    r_leds  <= '0;
                end
            endcase
        end
    end

    assign leds = r_leds;

endmodule

// File: tb/tb_led_stat.sv
module tb_led_stat;

    logic        clk;
    logic        reset, halt, br_cond, br_taken, jmp, page, clr, freeze;
    logic [11:0] pc, in_addr;
    logic [2:0]  sel;
    logic [15:0] leds;

    // Narrow instance so counter saturation is reachable in a few hundred cycles.
    logic        reset_s, page_s;
    logic [2:0]  pc_s, in_addr_s;
    logic [2:0]  sel_s;
    logic [3:0]  leds_s;

    led_stat #(.CNT_W(32), .LED_W(16), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .halt(halt), .br_cond(br_cond),
        .br_taken(br_taken), .jmp(jmp), .pc(pc), .in_addr(in_addr),
        .sel(sel), .page(page), .clr(clr), .freeze(freeze), .leds(leds)
    );

    led_stat #(.CNT_W(8), .LED_W(4), .ADDR_W(3)) dut_s (
        .clk(clk), .reset(reset_s), .halt(1'b0), .br_cond(1'b0),
        .br_taken(1'b0), .jmp(1'b0), .pc(pc_s), .in_addr(in_addr_s),
        .sel(sel_s), .page(page_s), .clr(1'b0), .freeze(1'b0), .leds(leds_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected LED values queued by the stimulus.
    logic [15:0] exp_q[$];
    bit          which_q[$];
    string       name_q[$];
    bit          done;

    int unsigned n_checks;
    int unsigned n_fail;

    task automatic expect_leds(input string nm, input bit which, input logic [15:0] v);
        exp_q.push_back(v);
        which_q.push_back(which);
        name_q.push_back(nm);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic br_pulse(input logic tk);
        br_cond  = 1'b1;
        br_taken = tk;
        tick(1);
        br_cond  = 1'b0;
        br_taken = 1'b0;
        tick(1);
    endtask

    // Monitor: compares LED outputs on the falling edge, away from updates.
    initial begin
        int unsigned cyc;
        logic [15:0] e, a;
        bit          w;
        string       nm;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        forever begin
            @(negedge clk);
            cyc++;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                w  = which_q.pop_front();
                nm = name_q.pop_front();
                a  = w ? {12'h000, leds_s} : leds;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: leds=0x%0h expected 0x%0h", nm, a, e);
                end
            end
            if (cyc > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: cycles=%0d expected done by 5000", cyc);
                done = 1'b1;
            end
            if (done) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        done      = 1'b0;
        reset     = 1'b0; halt = 1'b0; br_cond = 1'b0; br_taken = 1'b0;
        jmp       = 1'b0; page = 1'b0; clr = 1'b0; freeze = 1'b0;
        pc        = '0;   in_addr = '0; sel = 3'b010;
        reset_s   = 1'b0; page_s = 1'b1; pc_s = '0; in_addr_s = '0; sel_s = 3'b010;

        tick(2);
        expect_leds("reset_leds", 1'b0, 16'h0000);
        expect_leds("reset_leds_s", 1'b1, 16'h0000);

        // 100 edges after release: cyc=100, leds shows the value before the edge.
        reset = 1'b1;
        tick(100);
        expect_leds("run100", 1'b0, 16'h0063);

        for (int i = 0; i < 5; i++) br_pulse(i < 3);
        for (int i = 0; i < 2; i++) begin
            br_taken = 1'b1; tick(1); br_taken = 1'b0; tick(1);
        end
        sel = 3'b100; tick(1);
        expect_leds("taken_cnt", 1'b0, 16'h0003);
        sel = 3'b011; tick(1);
        expect_leds("cond_cnt", 1'b0, 16'h0005);

        br_cond = 1'b1; jmp = 1'b1; tick(1);
        br_cond = 1'b0; jmp = 1'b0; sel = 3'b101; tick(1);
        expect_leds("jmp_cnt", 1'b0, 16'h0001);
        sel = 3'b011; tick(1);
        expect_leds("cond_with_jmp", 1'b0, 16'h0006);

        // clr beats a same-cycle jump and zeroes every counter.
        clr = 1'b1; jmp = 1'b1; tick(1);
        clr = 1'b0; jmp = 1'b0; sel = 3'b101; tick(1);
        expect_leds("clr_jmp", 1'b0, 16'h0000);
        sel = 3'b010; tick(1);
        expect_leds("clr_cyc", 1'b0, 16'h0001);

        // cyc=2 here; halt freezes all counters.
        halt = 1'b1; br_cond = 1'b1; br_taken = 1'b1; jmp = 1'b1;
        tick(10);
        expect_leds("halt_cyc", 1'b0, 16'h0002);
        halt = 1'b0; br_cond = 1'b0; br_taken = 1'b0; jmp = 1'b0; sel = 3'b100;
        tick(1);
        expect_leds("halt_taken", 1'b0, 16'h0000);

        halt = 1'b1; clr = 1'b1; tick(1);
        clr = 1'b0; sel = 3'b010; tick(1);
        expect_leds("clr_in_halt", 1'b0, 16'h0000);
        halt = 1'b0;

        // Freeze: capture cond=2, then sel/page changes and counting are invisible.
        sel = 3'b011; clr = 1'b1; tick(1);
        clr = 1'b0;
        br_pulse(1'b0); br_pulse(1'b0);
        freeze = 1'b1; tick(1);
        expect_leds("freeze_capture", 1'b0, 16'h0002);
        for (int i = 0; i < 4; i++) br_pulse(1'b0);
        sel = 3'b010; page = 1'b1; tick(2);
        expect_leds("frozen", 1'b0, 16'h0002);
        freeze = 1'b0; page = 1'b0; tick(1);
        expect_leds("unfreeze_cyc", 1'b0, 16'h000F);
        sel = 3'b011; tick(1);
        expect_leds("count_in_hold", 1'b0, 16'h0006);

        sel = 3'b010; page = 1'b1; tick(1);
        expect_leds("page1_hi", 1'b0, 16'h0000);

        sel = 3'b000; in_addr = 12'hABC; tick(1);
        expect_leds("addr_switch", 1'b0, 16'hD5E0);
        sel = 3'b001; pc = 12'h123; tick(1);
        expect_leds("pc", 1'b0, 16'h0123);
        sel = 3'b110; tick(1);
        expect_leds("sel110", 1'b0, 16'h0000);
        sel = 3'b001; tick(1);
        sel = 3'b111; tick(1);
        expect_leds("sel111", 1'b0, 16'h0000);
        page = 1'b0;

        // Reset while HELD with a pending branch pulse.
        sel = 3'b011; freeze = 1'b1; tick(1);
        expect_leds("hold_pre_reset", 1'b0, 16'h0006);
        reset = 1'b0; br_cond = 1'b1; tick(1);
        expect_leds("mid_reset", 1'b0, 16'h0000);
        reset = 1'b1; br_cond = 1'b0; freeze = 1'b0; tick(1);
        expect_leds("post_reset_cond", 1'b0, 16'h0000);
        sel = 3'b010; tick(1);
        expect_leds("post_reset_cyc", 1'b0, 16'h0001);

        // Narrow instance: paging and saturation at 8'hFF.
        reset_s = 1'b1; tick(20);
        expect_leds("s_page1", 1'b1, 16'h0001);
        page_s = 1'b0; tick(1);
        expect_leds("s_page0", 1'b1, 16'h0004);
        page_s = 1'b1; tick(240);
        expect_leds("sat_hi", 1'b1, 16'h000F);
        page_s = 1'b0; tick(1);
        expect_leds("sat_lo", 1'b1, 16'h000F);
        tick(5);
        expect_leds("sat_nowrap", 1'b1, 16'h000F);
        sel_s = 3'b000; in_addr_s = 3'b101; tick(1);
        expect_leds("s_addr", 1'b1, 16'h000D);

        done = 1'b1;
    end

endmodule
